// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial-flash slave serving READ/JEDEC ID/STATUS-1 from a synchronous image RAM
module spi_flash_responder #(
    parameter int          ADDRW    = 15,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS1  = 8'h00
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             nCS,
    input  logic             CLK,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    output logic [ADDRW-1:0] MEMADDR,
    output logic             MEMRD,
    input  logic [7:0]       MEMDATA,
    output logic             BUSY
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
    state_t     state;
    logic [1:0] ncs_sync, clk_sync, mosi_sync;
    logic       ncs_h, clk_h;
    logic [6:0] cmd;
    logic [7:0] out_sr;
    logic [7:0] cmd_byte;
    logic [7:0] id_next;
    logic [4:0] bitcnt;
    logic [1:0] idcnt;
    logic       ld;
    logic       rise, fall, cs_high, cs_fall, mosi;
    assign mosi     = mosi_sync[1];
    assign rise     = clk_sync[1] & ~clk_h;
    assign fall     = ~clk_sync[1] & clk_h;
    assign cs_high  = ncs_sync[1];
    assign cs_fall  = ncs_h & ~ncs_sync[1];
    assign cmd_byte = {cmd, mosi};
    assign id_next  = idcnt == 2'd1 ? JEDEC_ID[15:8] : idcnt == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
    // nCS history resets low so a fresh high->low edge is required after RESET
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ncs_sync  <= 2'b00;
            clk_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            ncs_h     <= 1'b0;
            clk_h     <= 1'b0;
            state     <= IDLE;
            cmd       <= '0;
            out_sr    <= '0;
            bitcnt    <= '0;
            idcnt     <= '0;
            ld        <= 1'b0;
            MISO      <= 1'b0;
            MISO_OE   <= 1'b0;
            MEMADDR   <= '0;
            MEMRD     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[0], nCS};
            clk_sync  <= {clk_sync[0], CLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ncs_h     <= ncs_sync[1];
            clk_h     <= clk_sync[1];
            MEMRD     <= 1'b0;
            ld        <= MEMRD;
            if (cs_high) begin
                state   <= IDLE;
                MISO_OE <= 1'b0;
                MISO    <= 1'b0;
                out_sr  <= '0;
                bitcnt  <= '0;
                BUSY    <= 1'b0;
                ld      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state   <= CMD;
                        bitcnt  <= '0;
                        MISO_OE <= 1'b1;
                        MISO    <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                    CMD: if (rise) begin
                        cmd    <= cmd_byte[6:0];
                        bitcnt <= bitcnt == 5'd7 ? 5'd0 : bitcnt + 5'd1;
                        if (bitcnt == 5'd7) begin
                            state  <= cmd_byte == 8'h03 ? ADDR : cmd_byte == 8'h9F ? ID :
                                      cmd_byte == 8'h05 ? STAT : IGNORE;
                            out_sr <= cmd_byte == 8'h9F ? JEDEC_ID[23:16] : STATUS1;
                            idcnt  <= 2'd1;
                        end
                    end
                    // address accumulates straight into MEMADDR; upper bits fall off the top
                    ADDR: if (rise) begin
                        MEMADDR <= {MEMADDR[ADDRW-2:0], mosi};
                        bitcnt  <= bitcnt == 5'd23 ? 5'd0 : bitcnt + 5'd1;
                        if (bitcnt == 5'd23) begin
                            MEMRD <= 1'b1;
                            state <= DATA;
                        end
                    end
                    DATA, ID, STAT: if (fall) begin
                        MISO   <= out_sr[7];
                        bitcnt <= bitcnt == 5'd7 ? 5'd0 : bitcnt + 5'd1;
                        out_sr <= bitcnt != 5'd7 || state == DATA ? {out_sr[6:0], 1'b0} :
                                  state == ID ? id_next : STATUS1;
                        if (bitcnt == 5'd7 && state == DATA) begin
                            MEMADDR <= MEMADDR + ADDRW'(1);
                            MEMRD   <= 1'b1;
                        end
                        if (bitcnt == 5'd7 && state == ID && idcnt != 2'd3) idcnt <= idcnt + 2'd1;
                    end else if (ld) begin
                        out_sr <= MEMDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
